// File: rtl/pixel_pkg.sv
// Shared screen constants, pixel record and source identifiers for the VGA write path.

package pixel_pkg;

   localparam int unsigned SCREEN_W = 160;
   localparam int unsigned SCREEN_H = 120;

   typedef struct packed {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] colour;
   } pixel_t;

   typedef enum logic {
      SrcA,
      SrcB
   } src_e;

endpackage

// File: rtl/pixel_fifo.sv
// Show-ahead FIFO of pixel_t: the head entry is visible on head whenever empty is low.

module pixel_fifo
   import pixel_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic   clk,
   input  logic   resetn,
   input  logic   push,
   input  pixel_t push_data,
   input  logic   pop,
   output pixel_t head,
   output logic   full,
   output logic   empty
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   pixel_t            mem_q [DEPTH];
   logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]   count_q, count_d;
   logic              do_push, do_pop;

   assign full    = (count_q == CntW'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem_q[rd_ptr_q];

   always_comb begin
      count_d = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + 1'b1;
      end else if (!do_push && do_pop) begin
         count_d = count_q - 1'b1;
      end
   end

   // Storage is deliberately left unreset; head is only meaningful while !empty.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/pixel_write_queue.sv
// Round-robin merge of two pixel drawers into one buffered vga_adapter write stream.
// Off-screen clipping and drop_count are enabled by defining PIXEL_CLIP_EN.

module pixel_write_queue
   import pixel_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned X_MAX = SCREEN_W,
   parameter int unsigned Y_MAX = SCREEN_H
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       a_plot,
   input  logic [7:0] a_x,
   input  logic [6:0] a_y,
   input  logic [2:0] a_colour,
   output logic       a_ready,
   input  logic       b_plot,
   input  logic [7:0] b_x,
   input  logic [6:0] b_y,
   input  logic [2:0] b_colour,
   output logic       b_ready,
   output logic [7:0] vga_x,
   output logic [6:0] vga_y,
   output logic [2:0] vga_colour,
   output logic       vga_plot,
   input  logic       vga_ready,
   output logic       full,
   output logic       empty,
   output logic [7:0] drop_count
);

   src_e   rr_last_q;
   logic   grant_a, grant_b, accept, push;
   pixel_t in_pix, head;

   // On contention the source that did not win last time takes the slot.
   assign grant_a = a_plot && (!b_plot || rr_last_q == SrcB);
   assign grant_b = b_plot && (!a_plot || rr_last_q == SrcA);
   assign a_ready = grant_a && !full;
   assign b_ready = grant_b && !full;
   assign accept  = a_ready || b_ready;
   assign in_pix  = a_ready ? pixel_t'{x: a_x, y: a_y, colour: a_colour}
                            : pixel_t'{x: b_x, y: b_y, colour: b_colour};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rr_last_q <= SrcB;
      end else if (accept) begin
         rr_last_q <= a_ready ? SrcA : SrcB;
      end
   end

`ifdef PIXEL_CLIP_EN
   logic       off_screen;
   logic [7:0] drop_q;

   assign off_screen = (32'(in_pix.x) >= X_MAX) || (32'(in_pix.y) >= Y_MAX);
   // A clipped pixel still completes its handshake; it just never reaches the FIFO.
   assign push       = accept && !off_screen;
   assign drop_count = drop_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         drop_q <= '0;
      end else if (accept && off_screen && drop_q != 8'hff) begin
         drop_q <= drop_q + 8'd1;
      end
   end
`else
   localparam int unsigned unused_lims = X_MAX + Y_MAX;

   assign push       = accept;
   assign drop_count = '0;
`endif

   pixel_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk       (clk),
      .resetn    (resetn),
      .push      (push),
      .push_data (in_pix),
      .pop       (vga_plot && vga_ready),
      .head      (head),
      .full      (full),
      .empty     (empty)
   );

   assign vga_plot   = !empty;
   assign vga_x      = head.x;
   assign vga_y      = head.y;
   assign vga_colour = head.colour;

endmodule

// File: tb/tb_pixel_write_queue.sv
// Directed self-checking bench for pixel_write_queue (DEPTH=8); clip checks follow PIXEL_CLIP_EN.

module tb_pixel_write_queue;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       a_plot = 1'b0, b_plot = 1'b0;
   logic [7:0] a_x = '0, b_x = '0;
   logic [6:0] a_y = '0, b_y = '0;
   logic [2:0] a_colour = '0, b_colour = '0;
   logic       a_ready, b_ready;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_colour;
   logic       vga_plot;
   logic       vga_ready = 1'b1;
   logic       full, empty;
   logic [7:0] drop_count;

   int n_checks = 0;
   int n_pass   = 0;

   pixel_write_queue #(
      .DEPTH(8)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .a_plot     (a_plot),
      .a_x        (a_x),
      .a_y        (a_y),
      .a_colour   (a_colour),
      .a_ready    (a_ready),
      .b_plot     (b_plot),
      .b_x        (b_x),
      .b_y        (b_y),
      .b_colour   (b_colour),
      .b_ready    (b_ready),
      .vga_x      (vga_x),
      .vga_y      (vga_y),
      .vga_colour (vga_colour),
      .vga_plot   (vga_plot),
      .vga_ready  (vga_ready),
      .full       (full),
      .empty      (empty),
      .drop_count (drop_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      a_plot = 1'b0;
      b_plot = 1'b0;
      resetn = 1'b0;
      #2;
      resetn = 1'b1;
      step();
   endtask

   initial begin
      int sent, got, a_idx, b_idx;
      logic [7:0] exp_seq [4];

      // Reset state
      #2;
      check("rst_empty", 32'(empty), 1);
      check("rst_full", 32'(full), 0);
      check("rst_plot", 32'(vga_plot), 0);
      check("rst_drop", 32'(drop_count), 0);
      resetn = 1'b1;
      step();

      // Single push
      a_plot = 1'b1; a_x = 8'd5; a_y = 7'd21; a_colour = 3'b011;
      #1;
      check("single_a_ready", 32'(a_ready), 1);
      step();
      a_plot = 1'b0;
      #1;
      check("single_plot", 32'(vga_plot), 1);
      check("single_x", 32'(vga_x), 5);
      check("single_y", 32'(vga_y), 21);
      check("single_colour", 32'(vga_colour), 3);
      step();
      check("single_empty_after", 32'(empty), 1);

      // Contention: grants alternate A,B,A,B from reset
      do_reset();
      vga_ready = 1'b0;
      a_idx = 0; b_idx = 0;
      for (int i = 0; i < 4; i++) begin
         a_plot = 1'b1; b_plot = 1'b1;
         a_x = 8'(10 + a_idx); a_y = 7'd1; a_colour = 3'd1;
         b_x = 8'(20 + b_idx); b_y = 7'd2; b_colour = 3'd2;
         #1;
         check("cont_a_ready", 32'(a_ready), (i % 2 == 0) ? 1 : 0);
         check("cont_b_ready", 32'(b_ready), (i % 2 == 1) ? 1 : 0);
         if (i % 2 == 0) a_idx++; else b_idx++;
         step();
      end
      a_plot = 1'b0; b_plot = 1'b0;
      vga_ready = 1'b1;
      exp_seq[0] = 8'd10; exp_seq[1] = 8'd20; exp_seq[2] = 8'd11; exp_seq[3] = 8'd21;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("cont_plot", 32'(vga_plot), 1);
         check("cont_order", 32'(vga_x), 32'(exp_seq[i]));
         step();
      end
      check("cont_empty", 32'(empty), 1);

      // Backpressure: only DEPTH of 10 accepted, then drain in order
      do_reset();
      vga_ready = 1'b0;
      sent = 0;
      for (int i = 0; i < 10; i++) begin
         a_plot = 1'b1; a_x = 8'(30 + sent); a_y = 7'd3; a_colour = 3'd4;
         #1;
         check("bp_a_ready", 32'(a_ready), (i < 8) ? 1 : 0);
         if (i < 8) sent++;
         step();
      end
      check("bp_full", 32'(full), 1);
      check("bp_a_ready_full", 32'(a_ready), 0);
      vga_ready = 1'b1;
      #1;
      check("bp_no_passthrough", 32'(a_ready), 0);
      got = 0;
      for (int i = 0; i < 30 && got < 10; i++) begin
         a_plot = (sent < 10); a_x = 8'(30 + sent);
         #1;
         if (vga_plot) begin
            check("bp_drain_order", 32'(vga_x), 32'(30 + got));
            got++;
         end
         if (a_ready) sent++;
         step();
      end
      a_plot = 1'b0;
      check("bp_drained", 32'(got), 10);
      check("bp_sent", 32'(sent), 10);

      // Clipping path
      do_reset();
      vga_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         b_plot = 1'b1; b_colour = 3'd5;
         b_x = (i == 0) ? 8'd160 : (i == 1) ? 8'd0 : 8'd159;
         b_y = (i == 0) ? 7'd0 : (i == 1) ? 7'd120 : 7'd119;
         #1;
         check("clip_b_ready", 32'(b_ready), 1);
         step();
      end
      b_plot = 1'b0;
      vga_ready = 1'b1;
`ifdef PIXEL_CLIP_EN
      check("clip_drop", 32'(drop_count), 2);
      check("clip_x", 32'(vga_x), 159);
      check("clip_y", 32'(vga_y), 119);
      step();
      check("clip_empty", 32'(empty), 1);
      // Saturation
      for (int i = 0; i < 300; i++) begin
         a_plot = 1'b1; a_x = 8'd200; a_y = 7'd0;
         step();
      end
      a_plot = 1'b0;
      check("sat_drop", 32'(drop_count), 255);
      check("sat_empty", 32'(empty), 1);
`else
      check("noclip_drop", 32'(drop_count), 0);
      check("noclip_x0", 32'(vga_x), 160);
      step();
      check("noclip_y1", 32'(vga_y), 120);
      step();
      check("noclip_x2", 32'(vga_x), 159);
      step();
      check("noclip_empty", 32'(empty), 1);
`endif

      // Reset mid-operation with 5 queued entries
      do_reset();
      vga_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         a_plot = 1'b1; a_x = 8'(40 + i);
         step();
      end
      a_plot = 1'b0;
      check("mid_plot_before", 32'(vga_plot), 1);
      #2;
      resetn = 1'b0;
      #1;
      check("mid_plot_async", 32'(vga_plot), 0);
      check("mid_empty_async", 32'(empty), 1);
      #1;
      resetn = 1'b1;
      step();
      check("mid_empty_after", 32'(empty), 1);
      check("mid_drop_after", 32'(drop_count), 0);
      a_plot = 1'b1; b_plot = 1'b1;
      #1;
      check("mid_a_first", 32'(a_ready), 1);
      check("mid_b_wait", 32'(b_ready), 0);
      a_plot = 1'b0; b_plot = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pixel_write_queue.md
# pixel_write_queue

Downstream stage between the sprite drawing engines and the single `vga_adapter` write port in the 160x120 pizza-delivery display. It accepts pixel writes from two independent drawers: source A, the moving delivery box, and source B, the scenery/house drawer. It arbitrates between them round-robin and buffers the writes in a small FIFO. It then drains one pixel per accepted cycle to the adapter, optionally discarding off-screen coordinates.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; must be a power of 2, minimum 2.
- `X_MAX`, 160: first illegal x coordinate.
- `Y_MAX`, 120: first illegal y coordinate.

Ports:
- `clk` input 1: system clock (CLOCK_50 domain).
- `resetn` input 1: asynchronous, active-low reset.
- `a_plot` input 1: source A write request.
- `a_x` input 8: source A pixel x.
- `a_y` input 7: source A pixel y.
- `a_colour` input 3: source A colour.
- `a_ready` output 1: source A write accepted this cycle.
- `b_plot`, `b_x`, `b_y`, `b_colour`, `b_ready`: identical to the A ports, for source B.
- `vga_x` output 8: head pixel x, to the adapter.
- `vga_y` output 7: head pixel y, to the adapter.
- `vga_colour` output 3: head pixel colour, to the adapter.
- `vga_plot` output 1: head entry valid.
- `vga_ready` input 1: adapter can take the head pixel; tie high if unused.
- `full` output 1: count equals DEPTH.
- `empty` output 1: count equals 0.
- `drop_count` output 8: clipped-pixel counter, saturating.

## Operation
Handshake:
- A transfer on a source occurs when `x_plot && x_ready` are both high on a rising edge.
- While `plot` is high and `ready` is low, the source must hold x, y and colour stable.

Arbitration:
- At most one push per cycle.
- `rr_last` records the last granted source; it resets to B, so A wins first.
- If only one source requests and `!full`, that source is granted.
- If both request, the source other than `rr_last` is granted.
- `rr_last` updates only on a grant.
- `a_ready`/`b_ready` are combinational: grant and `!full`. `full` is taken from the registered count.
- There is no pass-through at full: a push is refused when count == DEPTH, even if a pop happens in the same cycle.

FIFO:
- Show-ahead organisation.
- `vga_plot = !empty`; `vga_x`, `vga_y`, `vga_colour` show the entry at `rd_ptr`.
- Pop occurs when `vga_plot && vga_ready`.
- Pointers are log2(DEPTH) bits and wrap naturally.
- Count is log2(DEPTH)+1 bits.
- Push and pop in the same cycle leave count unchanged.
- Push into an empty FIFO with pop the same cycle is impossible, because pop requires `!empty`.

Arithmetic:
- The coordinate comparison is unsigned at full port width.
- `drop_count` saturates at 255 and never wraps.

## Timing
- Reset values (asynchronous, immediate):
  - pointers, count, `rr_last`=B and `drop_count` cleared;
  - hence `empty`=1, `full`=0, `vga_plot`=0 and both readies follow grant logic from the cleared state.
- Memory contents are not reset; `vga_x`, `vga_y` and `vga_colour` are don't-care while `vga_plot`=0.
- Latency: a pixel pushed at edge N appears with `vga_plot`=1 in the cycle after edge N, i.e. 1 cycle.
- Throughput: 1 pixel per cycle in and out while `vga_ready`=1.
- Reset asserted mid-burst: all queued pixels are discarded and no partial write is issued. Sources must re-present their pixels after reset.
- With `vga_ready`=0 for DEPTH or more cycles under continuous requests, `full` rises and both readies fall. Order is preserved within each source.

## Configuration
`PIXEL_CLIP_EN`:
- Defined:
  - A granted pixel with x >= X_MAX or y >= Y_MAX completes its handshake (ready high) but is not written.
  - The clipped pixel still updates `rr_last`.
  - `drop_count` increments by 1, saturating.
  - Clipping is still gated by `!full`.
- Undefined:
  - All granted pixels are written unchanged.
  - `drop_count` is tied to 0.
  - No comparators are synthesised.

## Structure
- Package `pixel_pkg`:
  - screen constants `SCREEN_W`=160 and `SCREEN_H`=120, used as the defaults for X_MAX and Y_MAX;
  - packed struct `pixel_t` {x[7:0], y[6:0], colour[2:0]}, 18 bits.
- Sub-module `pixel_fifo`:
  - generic show-ahead FIFO of `pixel_t`;
  - push/pop interface plus full/empty.
- The top level holds the arbiter, the clip logic and `drop_count`.

## Test plan
- Single push: A pushes (5,21,3'b011) after reset, `vga_ready`=1 → `vga_plot`=1 next cycle with (5,21,3'b011); `empty` returns to 1 the cycle after.
- Contention: A and B request every cycle for 4 cycles → grant order A,B,A,B; output order matches.
- Backpressure: `vga_ready`=0, A streams 10 pixels, DEPTH=8 → exactly 8 accepted; `full`=1 and `a_ready`=0. Raise `vga_ready` → the 8 pixels drain in order, then the remaining 2 are accepted.
- Clipping with `PIXEL_CLIP_EN`: B pushes (160,0), (0,120) and (159,119) → only (159,119) is output; `drop_count`=2.
- Saturation with `PIXEL_CLIP_EN`: 300 off-screen pushes → `drop_count` stops at 255.
- Reset mid-operation: FIFO holding 5 entries, `resetn` pulsed low between edges → `vga_plot` falls immediately; `empty`=1 and `drop_count`=0 after release; the next push is granted to A first.
